// File: rtl/ex_pkg.sv
// Shared constants for the EX stage: bus widths, ALU op encodings,
// ID->EX bus field offsets and the multiplier FSM state type.
package ex_pkg;

  localparam int ID_TO_EX_BUS_WD  = 144;
  localparam int EX_TO_MEM_BUS_WD = 108;
  localparam int RDW_BUS_WD       = 39;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  // ID->EX bus field positions (LSB of each field)
  localparam int ALU_OP_LSB = 140;
  localparam int SRC1_LSB   = 108;
  localparam int SRC2_LSB   = 76;
  localparam int RDATA2_LSB = 44;
  localparam int FUNCT3_LSB = 41;
  localparam int LOAD_BIT   = 40;
  localparam int STORE_BIT  = 39;
  localparam int WB_WEN_BIT = 38;
  localparam int WADDR_LSB  = 33;
  localparam int PC_LSB     = 1;
  localparam int IS_MUL_BIT = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Data-memory request channel between the EX stage (master) and memory (slave).
interface ex_stage_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;

  modport master (
    output Address, MemWrite, MemRead, Write_data, Write_strb,
    input  Mem_Req_Ready
  );

  modport slave (
    input  Address, MemWrite, MemRead, Write_data, Write_strb,
    output Mem_Req_Ready
  );
endinterface

// File: rtl/ex_alu.sv
// Combinational RV32 integer ALU; unused op encodings yield zero.
module ex_alu
  import ex_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  // Select the operation result by alu_op
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = src1 + src2;
      ALU_SUB:  result = src1 - src2;
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_SLT:  result = {31'd0, $signed(src1) < $signed(src2)};
      ALU_SLTU: result = {31'd0, src1 < src2};
      ALU_SLL:  result = src1 << src2[4:0];
      ALU_SRL:  result = src1 >> src2[4:0];
      ALU_SRA:  result = $signed(src1) >>> src2[4:0];
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: latches the ID->EX bus, computes the ALU result,
// issues and holds the data-memory request, and drives the EX->MEM and
// forwarding buses. Define RV32M_EN to enable the iterative multiplier
// for is_mul instructions.
module ex_stage
  import ex_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MEM_Allow_in,
  output logic                        EX_Allow_in,
  input  logic                        ID_to_EX_Valid,
  input  logic [ID_TO_EX_BUS_WD-1:0]  ID_to_EX_Bus,
  output logic                        EX_to_MEM_Valid,
  output logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus,
  output logic [RDW_BUS_WD-1:0]       rdw_EX_Bus,
  ex_stage_if.master                  dmem
);

  logic                       ex_valid;
  logic                       req_done;
  logic [ID_TO_EX_BUS_WD-1:0] id_bus_q;

  logic [3:0]  alu_op;
  logic [31:0] src1, src2, rdata2, pc;
  logic [2:0]  funct3;
  logic        load, store, wb_wen, is_mul;
  logic [4:0]  waddr;

  logic [31:0] alu_result, result;
  logic        mem_req, ex_ready, ex_leave, mul_ok, fwd_ready;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] wdata;

  assign alu_op = id_bus_q[ALU_OP_LSB +: 4];
  assign src1   = id_bus_q[SRC1_LSB +: 32];
  assign src2   = id_bus_q[SRC2_LSB +: 32];
  assign rdata2 = id_bus_q[RDATA2_LSB +: 32];
  assign funct3 = id_bus_q[FUNCT3_LSB +: 3];
  assign load   = id_bus_q[LOAD_BIT];
  assign store  = id_bus_q[STORE_BIT];
  assign wb_wen = id_bus_q[WB_WEN_BIT];
  assign waddr  = id_bus_q[WADDR_LSB +: 5];
  assign pc     = id_bus_q[PC_LSB +: 32];
  assign is_mul = id_bus_q[IS_MUL_BIT];

  ex_alu u_alu (
    .alu_op (alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (alu_result)
  );

`ifdef RV32M_EN
  mul_state_e  mul_state;
  logic [31:0] mcand, mplier, mul_prod;
  logic [5:0]  mul_cnt;

  // Shift-add multiply, one multiplier bit per cycle; DONE holds until the op leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_state <= MUL_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      mul_prod  <= '0;
      mul_cnt   <= '0;
    end else begin
      case (mul_state)
        MUL_IDLE: if (ex_valid && is_mul) begin
          mcand     <= src1;
          mplier    <= src2;
          mul_prod  <= '0;
          mul_cnt   <= 6'd32;
          mul_state <= MUL_BUSY;
        end
        MUL_BUSY: begin
          if (mplier[0]) mul_prod <= mul_prod + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt - 6'd1;
          if (mul_cnt == 6'd1) mul_state <= MUL_DONE;
        end
        MUL_DONE: if (EX_Allow_in) mul_state <= MUL_IDLE;
        default:  mul_state <= MUL_IDLE;
      endcase
    end
  end

  assign mul_ok = ~(ex_valid & is_mul) | (mul_state == MUL_DONE);
  assign result = is_mul ? mul_prod : alu_result;
`else
  logic unused_is_mul;
  assign unused_is_mul = is_mul;
  assign mul_ok        = 1'b1;
  assign result        = alu_result;
`endif

  assign mem_req         = ex_valid & (load | store) & ~req_done;
  assign ex_ready        = (~(load | store) & mul_ok) | req_done | (mem_req & dmem.Mem_Req_Ready);
  assign EX_Allow_in     = ~ex_valid | (ex_ready & MEM_Allow_in);
  assign EX_to_MEM_Valid = ex_valid & ex_ready;
  assign ex_leave        = ex_valid & ex_ready & MEM_Allow_in;
  assign fwd_ready       = ex_ready & ~load;

  // Valid flag and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
    end else if (EX_Allow_in) begin
      ex_valid <= ID_to_EX_Valid;
    end
    if (ID_to_EX_Valid && EX_Allow_in) begin
      id_bus_q <= ID_to_EX_Bus;
    end
  end

  // Remember an accepted memory request so a stalled instruction does not reissue it
  always_ff @(posedge clk) begin
    if (rst) begin
      req_done <= 1'b0;
    end else if (ex_leave) begin
      req_done <= 1'b0;
    end else if (mem_req && dmem.Mem_Req_Ready) begin
      req_done <= 1'b1;
    end
  end

  // Store byte-lane placement from the low address bits
  always_comb begin
    off   = result[1:0];
    strb  = '0;
    wdata = '0;
    case (funct3[1:0])
      2'b00: begin
        strb  = 4'b0001 << off;
        wdata = {4{rdata2[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << {off[1], 1'b0};
        wdata = {2{rdata2[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = rdata2;
      end
    endcase
  end

  assign dmem.Address    = {result[31:2], 2'b00};
  assign dmem.MemRead    = mem_req & load;
  assign dmem.MemWrite   = mem_req & store;
  assign dmem.Write_data = wdata;
  assign dmem.Write_strb = strb;

  assign EX_to_MEM_Bus = {rdata2, result, funct3, load, store, store, wb_wen, waddr, pc};
  assign rdw_EX_Bus    = {fwd_ready, wb_wen & ex_valid, waddr, result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expectations.
module tb_ex_stage;
  import ex_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         MEM_Allow_in;
  logic         EX_Allow_in;
  logic         ID_to_EX_Valid;
  logic [143:0] ID_to_EX_Bus;
  logic         EX_to_MEM_Valid;
  logic [107:0] EX_to_MEM_Bus;
  logic [38:0]  rdw_EX_Bus;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;
  int lat;
  int allow_busy;
  logic [31:0] res;

  ex_stage_if dmem ();

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .MEM_Allow_in    (MEM_Allow_in),
    .EX_Allow_in     (EX_Allow_in),
    .ID_to_EX_Valid  (ID_to_EX_Valid),
    .ID_to_EX_Bus    (ID_to_EX_Bus),
    .EX_to_MEM_Valid (EX_to_MEM_Valid),
    .EX_to_MEM_Bus   (EX_to_MEM_Bus),
    .rdw_EX_Bus      (rdw_EX_Bus),
    .dmem            (dmem.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] mk_bus(
    input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
    input logic [31:0] rd2, input logic [2:0] f3, input logic ld, input logic st,
    input logic wen, input logic [4:0] wa, input logic [31:0] pc, input logic mul);
    return {op, s1, s2, rd2, f3, ld, st, wen, wa, pc, mul};
  endfunction

  // Present one instruction for a single edge; EX must be empty on entry
  task automatic issue(input logic [143:0] bus);
    ID_to_EX_Valid = 1'b1;
    ID_to_EX_Bus   = bus;
    step;
    ID_to_EX_Valid = 1'b0;
  endtask

  logic [3:0]  t_op  [12] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
                              ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, 4'd12, 4'd15};
  logic [31:0] t_a   [12] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFFFFF, 32'd1,
                              32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFF};
  logic [31:0] t_b   [12] = '{32'd7, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F, 32'd1, 32'hFFFFFFFF,
                              32'd1, 32'h0000003F, 32'd4, 32'd4, 32'd5, 32'd1};
  logic [31:0] t_exp [12] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F, 32'd1, 32'd1,
                              32'd0, 32'h80000000, 32'h08000000, 32'hF8000000, 32'd0, 32'd0};

  initial begin
    rst = 1'b1;
    MEM_Allow_in = 1'b1;
    ID_to_EX_Valid = 1'b0;
    ID_to_EX_Bus = '0;
    dmem.Mem_Req_Ready = 1'b0;
    step;
    step;
    @(negedge clk);
    check("rst_valid", EX_to_MEM_Valid, 1'b0);
    check("rst_memread", dmem.MemRead, 1'b0);
    check("rst_memwrite", dmem.MemWrite, 1'b0);
    check("rst_allow", EX_Allow_in, 1'b1);
    step;
    rst = 1'b0;

    // ADD 5 + -1
    issue(mk_bus(ALU_ADD, 32'd5, 32'hFFFFFFFF, 32'h11, 3'b000, 1'b0, 1'b0, 1'b1, 5'd3, 32'h100, 1'b0));
    @(negedge clk);
    check("add_valid", EX_to_MEM_Valid, 1'b1);
    check("add_bus", EX_to_MEM_Bus, {32'h11, 32'd4, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h100});
    check("add_memread", dmem.MemRead, 1'b0);
    check("add_memwrite", dmem.MemWrite, 1'b0);
    check("add_rdw", rdw_EX_Bus, {1'b1, 1'b1, 5'd3, 32'd4});
    step;
    @(negedge clk);
    check("add_drained", EX_to_MEM_Valid, 1'b0);
    step;

    // ALU op table
    for (int i = 0; i < 12; i++) begin
      issue(mk_bus(t_op[i], t_a[i], t_b[i], 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 1'b0));
      @(negedge clk);
      check($sformatf("alu_op%0d", t_op[i]), EX_to_MEM_Bus[75:44], t_exp[i]);
      step;
    end

    // SB to 0x1003 with memory stalling three cycles
    issue(mk_bus(ALU_ADD, 32'h1000, 32'd3, 32'h000000AB, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 1'b0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("sb_memwrite_wait", dmem.MemWrite, 1'b1);
      check("sb_valid_wait", EX_to_MEM_Valid, 1'b0);
      check("sb_addr", dmem.Address, 32'h1000);
      check("sb_strb", dmem.Write_strb, 4'b1000);
      check("sb_data", dmem.Write_data, 32'hABABABAB);
      step;
    end
    dmem.Mem_Req_Ready = 1'b1;
    @(negedge clk);
    check("sb_memwrite_acc", dmem.MemWrite, 1'b1);
    check("sb_valid_acc", EX_to_MEM_Valid, 1'b1);
    check("sb_mem_wen", EX_to_MEM_Bus[38], 1'b1);
    step;
    dmem.Mem_Req_Ready = 1'b0;
    @(negedge clk);
    check("sb_memwrite_after", dmem.MemWrite, 1'b0);
    check("sb_valid_after", EX_to_MEM_Valid, 1'b0);
    step;

    // SH to 0x1006 and SW to 0x2008, memory ready
    dmem.Mem_Req_Ready = 1'b1;
    issue(mk_bus(ALU_ADD, 32'h1000, 32'd6, 32'h1234ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h204, 1'b0));
    @(negedge clk);
    check("sh_addr", dmem.Address, 32'h1004);
    check("sh_strb", dmem.Write_strb, 4'b1100);
    check("sh_data", dmem.Write_data, 32'hABCDABCD);
    check("sh_valid", EX_to_MEM_Valid, 1'b1);
    step;
    issue(mk_bus(ALU_ADD, 32'h2000, 32'd8, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0, 32'h208, 1'b0));
    @(negedge clk);
    check("sw_addr", dmem.Address, 32'h2008);
    check("sw_strb", dmem.Write_strb, 4'b1111);
    check("sw_data", dmem.Write_data, 32'hDEADBEEF);
    step;

    // LW accepted while MEM stalls for two cycles
    pulses = 0;
    issue(mk_bus(ALU_ADD, 32'h2000, 32'd4, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd7, 32'h300, 1'b0));
    MEM_Allow_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (dmem.MemRead) pulses++;
      check("lw_valid_hold", EX_to_MEM_Valid, 1'b1);
      check("lw_allow_hold", EX_Allow_in, 1'b0);
      check("lw_fwd_hold", rdw_EX_Bus[38], 1'b0);
      check("lw_bus_hold", EX_to_MEM_Bus, {32'd0, 32'h2004, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h300});
      step;
    end
    MEM_Allow_in = 1'b1;
    @(negedge clk);
    if (dmem.MemRead) pulses++;
    check("lw_valid_release", EX_to_MEM_Valid, 1'b1);
    check("lw_allow_release", EX_Allow_in, 1'b1);
    check("lw_fwd_release", rdw_EX_Bus[38], 1'b0);
    step;
    @(negedge clk);
    check("lw_drained", EX_to_MEM_Valid, 1'b0);
    check("lw_memread_pulses", pulses, 1);
    step;

    // Reset while a completed request is held, then check req_done was cleared
    MEM_Allow_in = 1'b0;
    issue(mk_bus(ALU_ADD, 32'h3000, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd2, 32'h400, 1'b0));
    @(negedge clk);
    check("rstmid_memread_first", dmem.MemRead, 1'b1);
    step;
    @(negedge clk);
    check("rstmid_memread_held", dmem.MemRead, 1'b0);
    step;
    rst = 1'b1;
    step;
    @(negedge clk);
    check("rstmid_valid", EX_to_MEM_Valid, 1'b0);
    check("rstmid_memread", dmem.MemRead, 1'b0);
    check("rstmid_allow", EX_Allow_in, 1'b1);
    step;
    rst = 1'b0;
    MEM_Allow_in = 1'b1;
    dmem.Mem_Req_Ready = 1'b0;
    issue(mk_bus(ALU_ADD, 32'h3000, 32'd4, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd2, 32'h404, 1'b0));
    @(negedge clk);
    check("postrst_memread", dmem.MemRead, 1'b1);
    check("postrst_valid", EX_to_MEM_Valid, 1'b0);
    step;
    dmem.Mem_Req_Ready = 1'b1;
    @(negedge clk);
    check("postrst_valid_acc", EX_to_MEM_Valid, 1'b1);
    step;
    dmem.Mem_Req_Ready = 1'b0;
    @(negedge clk);
    check("postrst_drained", EX_to_MEM_Valid, 1'b0);
    step;

`ifdef RV32M_EN
    // 7 * 6 on the iterative multiplier
    lat = -1;
    allow_busy = 0;
    res = '0;
    issue(mk_bus(ALU_ADD, 32'd7, 32'd6, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9, 32'h500, 1'b1));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (EX_to_MEM_Valid) begin
        lat = c;
        res = EX_to_MEM_Bus[75:44];
        break;
      end
      if (EX_Allow_in) allow_busy++;
      step;
    end
    check("mul_latency", lat, 33);
    check("mul_result", res, 32'd42);
    check("mul_allow_busy", allow_busy, 0);
    step;
`else
    // is_mul ignored: executes as its alu_op
    issue(mk_bus(ALU_ADD, 32'd7, 32'd6, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9, 32'h500, 1'b1));
    @(negedge clk);
    check("mul_ignored_valid", EX_to_MEM_Valid, 1'b1);
    check("mul_ignored_result", EX_to_MEM_Bus[75:44], 32'd13);
    step;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- RV32 execute stage of the 5-stage custom_cpu pipeline, between ID and MEM.
- Latches the ID→EX bus and computes the ALU result.
- Issues the data-memory request for loads and stores, and holds it until the memory accepts.
- Forwards the EX→MEM bus (108 bits) and an EX forwarding (rdw) bus back to ID.

Parameters:
- ID_TO_EX_BUS_WD, 144, input bus width (fixed by package).
- EX_TO_MEM_BUS_WD, 108, output bus width.
- RDW_BUS_WD, 39, forwarding bus width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- MEM_Allow_in  in  1  MEM stage can accept
- EX_Allow_in  out  1  EX can accept from ID
- ID_to_EX_Valid  in  1  ID bus valid
- ID_to_EX_Bus  in  144  {alu_op[143:140], src1[139:108], src2[107:76], rf_rdata2[75:44], funct3[43:41], load[40], store[39], wb_wen[38], rf_waddr[37:33], pc[32:1], is_mul[0]}
- EX_to_MEM_Valid  out  1  output bus valid
- EX_to_MEM_Bus  out  108  {rf_rdata2, result, funct3, load, store, mem_wen, wb_wen, rf_waddr, pc}
- Address  out  32  word-aligned memory address ({result[31:2], 2'b00})
- MemWrite  out  1  store request
- MemRead  out  1  load request
- Write_data  out  32  store data shifted to byte lane
- Write_strb  out  4  byte enables
- Mem_Req_Ready  in  1  memory accepts request
- rdw_EX_Bus  out  39  {fwd_ready, wb_wen & EX_Valid, rf_waddr, result}

Behaviour:
- Reset:
  - EX_Valid = 0, req_done = 0, mul FSM = IDLE.
  - Outputs: EX_to_MEM_Valid = 0, MemRead = 0, MemWrite = 0.
- Input register:
  - EX_Valid loads ID_to_EX_Valid when EX_Allow_in.
  - The bus register loads when ID_to_EX_Valid & EX_Allow_in.
- ALU, selected by alu_op:
  - Encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
  - Shifts use src2[4:0]. SLT/SLTU produce a 0/1 zero-extended result.
  - Encodings 10-15 give result 0.
- Memory request:
  - mem_req = EX_Valid & (load | store) & ~req_done.
  - MemRead = mem_req & load; MemWrite = mem_req & store.
  - Handshake completes when mem_req & Mem_Req_Ready. On that cycle req_done sets; it clears when the instruction leaves EX.
  - The request stays asserted with stable Address, Write_data and Write_strb until accepted.
- Store lanes, with off = result[1:0]:
  - SB: strb = 4'b0001 << off; data = rdata2[7:0] replicated ×4.
  - SH: strb = 4'b0011 << {off[1],1'b0}; data = rdata2[15:0] replicated ×2.
  - SW: strb = 4'b1111; data = rdata2.
- Handshake:
  - EX_Ready = ~(load|store) & mul_ok | req_done | (mem_req & Mem_Req_Ready).
  - mul_ok = 1 unless an RV32M op is in progress (see Optional Feature).
  - EX_Allow_in = ~EX_Valid | EX_Ready & MEM_Allow_in.
  - EX_to_MEM_Valid = EX_Valid & EX_Ready.
  - mem_wen = store.
- Forwarding bus:
  - fwd_ready = EX_Ready & ~load. Load data is never forwarded from EX, so ID stalls.
- Stall while holding: when EX_Ready = 1 but MEM_Allow_in = 0, the instruction holds, req_done stays 1, and the request is not reissued.
- Reset mid-request: the request is dropped; req_done clears.

Optional Feature:
- Macro: RV32M_EN.
- Defined: is_mul instructions use a 32-cycle iterative shift-add multiplier.
  - FSM states: IDLE → BUSY (on entry EX_Valid & is_mul, load multiplicand/multiplier/counter = 32) → DONE (counter = 0).
  - DONE → IDLE when the instruction advances (EX_Allow_in).
  - mul_ok = (state == DONE); result = low 32 bits of the product.
- Undefined: is_mul is ignored; the instruction executes as its alu_op.

Decomposition:
- Package ex_pkg holds:
  - bus width constants;
  - ALU op encodings;
  - bus field offsets;
  - the multiplier FSM state encoding.
- Sub-module: ex_alu (combinational ALU).
- The multiplier stays inline under RV32M_EN.

Test Plan:
- ADD, src1 = 5, src2 = 0xFFFFFFFF, MEM_Allow_in = 1 → next cycle EX_to_MEM_Valid = 1, result = 4, no MemRead/MemWrite.
- SB, result = 0x1003, rdata2 = 0xAB, Mem_Req_Ready low for 3 cycles then high:
  - MemWrite holds 4 cycles; Address = 0x1000; strb = 4'b1000; Write_data = 0xABABABAB.
  - EX_to_MEM_Valid asserts only on the accept cycle.
- LW accepted while MEM_Allow_in = 0 for 2 cycles → exactly one MemRead pulse; the bus holds; fwd_ready = 0 throughout.
- SRA, src1 = 0x80000000, src2 = 4 → 0xF8000000. SLTU, 1 vs 0xFFFFFFFF → 1.
- rst asserted mid-request → next cycle EX_Valid = 0, MemRead = 0, req_done = 0.
- RV32M_EN, is_mul, 7 × 6 → EX_to_MEM_Valid 33 cycles after entry, result = 42, EX_Allow_in = 0 while BUSY.
